// File: rtl/pipe_stage_ctrl.sv
// Sequencing controller for a chain of pipeline-register walls: tracks a valid bit
// per stage, builds collapse-bubble enables, and runs the flush and drain sequences.
module pipe_stage_ctrl #(
    parameter int STAGES       = 4,
    parameter int FLUSH_CYCLES = 2
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         in_valid,
    output logic                         in_ready,
    output logic                         out_valid,
    input  logic                         out_ready,
    input  logic                         flush,
    input  logic                         drain,
    output logic                         drain_done,
    output logic [STAGES-1:0]            stage_en,
    output logic [STAGES-1:0]            stage_softReset,
    output logic [STAGES-1:0]            stage_valid,
    output logic [$clog2(STAGES+1)-1:0]  occupancy,
    output logic                         busy
);

    localparam int OW = $clog2(STAGES+1);
    localparam logic [3:0] CNT_LOAD = 4'(FLUSH_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        FLUSH,
        DRAIN
    } state_t;

    state_t            state;
    logic [3:0]        cnt;
    logic [STAGES-1:0] v;
    logic [STAGES-1:0] v_next;
    logic [STAGES-1:0] en_w;
    logic              accept;
    logic              drain_held;
    logic              carry;

    // A stage may load when it is empty or the stage ahead of it is moving.
    always_comb begin
        en_w  = '0;
        carry = out_ready;
        for (int i = STAGES - 1; i >= 0; i--) begin
            carry   = !v[i] | carry;
            en_w[i] = carry;
        end
    end

    assign in_ready  = reset & en_w[0] & !flush & !drain & (state != FLUSH);
    assign out_valid = v[STAGES-1] & !flush & (state != FLUSH);
    assign accept    = in_valid & in_ready;

    always_comb begin
        v_next    = v;
        v_next[0] = en_w[0] ? accept : v[0];
        for (int i = 1; i < STAGES; i++) begin
            v_next[i] = en_w[i] ? v[i-1] : v[i];
        end
    end

    always_comb begin
        stage_en = '0;
        if (state == FLUSH) begin
            stage_en = '1;
        end else if (!flush) begin
            stage_en = en_w;
        end
        stage_en = stage_en & {STAGES{reset}};
    end

    always_comb begin
        occupancy = '0;
        for (int i = 0; i < STAGES; i++) begin
            occupancy = occupancy + OW'(v[i]);
        end
    end

    assign stage_softReset = {STAGES{state == FLUSH}};
    assign stage_valid     = v;
    assign busy            = (state != IDLE);

    // drain_held remembers a completed drain so a held level request pulses only once.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            v          <= '0;
            cnt        <= '0;
            drain_done <= 1'b0;
            drain_held <= 1'b0;
        end else begin
            drain_done <= 1'b0;
            if (!drain) begin
                drain_held <= 1'b0;
            end
            if (flush) begin
                state <= FLUSH;
                cnt   <= CNT_LOAD;
                v     <= '0;
            end else begin
                case (state)
                    FLUSH: begin
                        v <= '0;
                        if (cnt == 4'd0) begin
                            state <= (drain && !drain_held) ? DRAIN : IDLE;
                        end else begin
                            cnt <= cnt - 4'd1;
                        end
                    end
                    IDLE: begin
                        v <= v_next;
                        if (drain) begin
                            if (!drain_held) begin
                                drain_done <= 1'b1;
                                drain_held <= 1'b1;
                            end
                        end else if (accept) begin
                            state <= RUN;
                        end
                    end
                    RUN: begin
                        v <= v_next;
                        if (drain) begin
                            if (v_next == '0) begin
                                drain_done <= 1'b1;
                                drain_held <= 1'b1;
                                state      <= IDLE;
                            end else begin
                                state <= DRAIN;
                            end
                        end else if (v_next == '0) begin
                            state <= IDLE;
                        end
                    end
                    DRAIN: begin
                        v <= v_next;
                        if (!drain) begin
                            state <= (v_next == '0) ? IDLE : RUN;
                        end else if (v_next == '0) begin
                            drain_done <= 1'b1;
                            drain_held <= 1'b1;
                            state      <= IDLE;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_pipe_stage_ctrl.sv
// Directed bench for pipe_stage_ctrl: a shadow datapath follows stage_en so bundle
// order can be checked against the IDs the bench injected.
module tb_pipe_stage_ctrl;

    localparam int STAGES = 4;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       in_valid = 1'b0;
    logic       out_ready = 1'b0;
    logic       flush = 1'b0;
    logic       drain = 1'b0;
    logic       in_ready, out_valid, drain_done, busy;
    logic [3:0] stage_en, stage_softReset, stage_valid;
    logic [2:0] occupancy;

    int         checks = 0;
    int         errors = 0;
    int         data [STAGES];
    int         in_id = 0;
    int         id_snap;
    logic [3:0] en_snap;

    pipe_stage_ctrl #(.STAGES(4), .FLUSH_CYCLES(2)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .out_valid(out_valid), .out_ready(out_ready), .flush(flush), .drain(drain),
        .drain_done(drain_done), .stage_en(stage_en), .stage_softReset(stage_softReset),
        .stage_valid(stage_valid), .occupancy(occupancy), .busy(busy)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog expired got=timeout exp=finish");
        $fatal(1, "[TB] watchdog");
    end

    task automatic tick();
        en_snap = stage_en;
        id_snap = in_id;
        @(posedge clk);
        for (int i = STAGES - 1; i > 0; i--) if (en_snap[i]) data[i] = data[i-1];
        if (en_snap[0]) data[0] = id_snap;
        @(negedge clk);
    endtask

    task automatic test_reset();
        #1;
        checks++; if (stage_en !== 4'b0000) begin errors++; $display("[TB] FAIL reset_stage_en got=%b exp=0000", stage_en); end
        checks++; if (stage_valid !== 4'b0000) begin errors++; $display("[TB] FAIL reset_stage_valid got=%b exp=0000", stage_valid); end
        checks++; if ({in_ready, out_valid, drain_done, busy} !== 4'b0000) begin errors++; $display("[TB] FAIL reset_flags got=%b exp=0000", {in_ready, out_valid, drain_done, busy}); end
        in_valid = 1'b1; out_ready = 1'b1;
        #1;
        checks++; if (in_ready !== 1'b0) begin errors++; $display("[TB] FAIL reset_in_ready_held got=%b exp=0", in_ready); end
        @(negedge clk); @(negedge clk);
        reset = 1'b1; in_valid = 1'b0;
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("[TB] FAIL reset_release_in_ready got=%b exp=1", in_ready); end
        checks++; if (stage_en !== 4'b1111) begin errors++; $display("[TB] FAIL reset_release_stage_en got=%b exp=1111", stage_en); end
    endtask

    task automatic test_streaming();
        int peak = 0;
        for (int c = 0; c < 16; c++) begin
            in_valid = (c < 8); in_id = c + 1; out_ready = 1'b1;
            #1;
            if (c < 8) begin
                checks++; if (in_ready !== 1'b1) begin errors++; $display("[TB] FAIL stream_in_ready cyc=%0d got=%b exp=1", c, in_ready); end
            end
            checks++; if (out_valid !== ((c >= 4) && (c < 12))) begin errors++; $display("[TB] FAIL stream_out_valid cyc=%0d got=%b exp=%b", c, out_valid, ((c >= 4) && (c < 12))); end
            if ((c >= 4) && (c < 12)) begin
                checks++; if (data[3] !== c - 3) begin errors++; $display("[TB] FAIL stream_order cyc=%0d got=%0d exp=%0d", c, data[3], c - 3); end
            end
            if (int'(occupancy) > peak) peak = int'(occupancy);
            tick();
        end
        in_valid = 1'b0;
        #1;
        checks++; if (peak !== 4) begin errors++; $display("[TB] FAIL stream_peak_occupancy got=%0d exp=4", peak); end
        checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL stream_end_busy got=%b exp=0", busy); end
    endtask

    task automatic test_backpressure();
        for (int c = 0; c < 14; c++) begin
            in_valid = (c < 9); in_id = c + 1; out_ready = !((c >= 4) && (c <= 8));
            #1;
            if ((c >= 4) && (c <= 8)) begin
                checks++; if (stage_en !== 4'b0000) begin errors++; $display("[TB] FAIL bp_stage_en cyc=%0d got=%b exp=0000", c, stage_en); end
                checks++; if (in_ready !== 1'b0) begin errors++; $display("[TB] FAIL bp_in_ready cyc=%0d got=%b exp=0", c, in_ready); end
                checks++; if (occupancy !== 3'd4) begin errors++; $display("[TB] FAIL bp_occupancy cyc=%0d got=%0d exp=4", c, occupancy); end
            end
            if ((c >= 9) && (c <= 12)) begin
                checks++; if (out_valid !== 1'b1) begin errors++; $display("[TB] FAIL bp_emit_valid cyc=%0d got=%b exp=1", c, out_valid); end
                checks++; if (data[3] !== c - 8) begin errors++; $display("[TB] FAIL bp_emit_order cyc=%0d got=%0d exp=%0d", c, data[3], c - 8); end
            end
            tick();
        end
        #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL bp_end_busy got=%b exp=0", busy); end
    endtask

    task automatic test_bubble_collapse();
        for (int c = 0; c < 9; c++) begin
            in_valid = (c == 0) || (c == 2); in_id = (c == 0) ? 1 : 2;
            out_ready = (c == 0) || (c >= 7);
            #1;
            if ((c == 5) || (c == 6)) begin
                checks++; if (stage_valid !== 4'b1100) begin errors++; $display("[TB] FAIL bubble_valid cyc=%0d got=%b exp=1100", c, stage_valid); end
                checks++; if (occupancy !== 3'd2) begin errors++; $display("[TB] FAIL bubble_occupancy cyc=%0d got=%0d exp=2", c, occupancy); end
            end
            if (c >= 7) begin
                checks++; if ((out_valid !== 1'b1) || (data[3] !== c - 6)) begin errors++; $display("[TB] FAIL bubble_emit cyc=%0d got=%b/%0d exp=1/%0d", c, out_valid, data[3], c - 6); end
            end
            tick();
        end
        out_ready = 1'b1;
        #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL bubble_end_busy got=%b exp=0", busy); end
    endtask

    task automatic test_flush();
        for (int c = 0; c < 8; c++) begin
            in_valid = (c < 3) || (c == 4); out_ready = (c >= 4); flush = (c == 4); in_id = c + 1;
            #1;
            if (c == 4) begin
                checks++; if (stage_valid !== 4'b1110) begin errors++; $display("[TB] FAIL flush_prefill got=%b exp=1110", stage_valid); end
                checks++; if ({in_ready, out_valid} !== 2'b00) begin errors++; $display("[TB] FAIL flush_cycle_handshake got=%b exp=00", {in_ready, out_valid}); end
            end
            if ((c == 5) || (c == 6)) begin
                checks++; if (stage_softReset !== 4'b1111) begin errors++; $display("[TB] FAIL flush_softreset cyc=%0d got=%b exp=1111", c, stage_softReset); end
                checks++; if (stage_valid !== 4'b0000) begin errors++; $display("[TB] FAIL flush_valid cyc=%0d got=%b exp=0000", c, stage_valid); end
                checks++; if ({stage_en, in_ready, out_valid, busy} !== 7'b1111001) begin errors++; $display("[TB] FAIL flush_outputs cyc=%0d got=%b exp=1111001", c, {stage_en, in_ready, out_valid, busy}); end
            end
            if (c == 7) begin
                checks++; if ({stage_softReset, busy} !== 5'b00000) begin errors++; $display("[TB] FAIL flush_exit got=%b exp=00000", {stage_softReset, busy}); end
            end
            tick();
        end
    endtask

    task automatic test_flush_extend();
        for (int c = 0; c < 5; c++) begin
            in_valid = 1'b0; flush = (c <= 1);
            #1;
            if ((c >= 1) && (c <= 3)) begin
                checks++; if (stage_softReset !== 4'b1111) begin errors++; $display("[TB] FAIL flush_ext_softreset cyc=%0d got=%b exp=1111", c, stage_softReset); end
            end
            if (c == 4) begin
                checks++; if ({stage_softReset, busy} !== 5'b00000) begin errors++; $display("[TB] FAIL flush_ext_exit got=%b exp=00000", {stage_softReset, busy}); end
            end
            tick();
        end
    endtask

    task automatic test_drain();
        int emits = 0;
        int pulses = 0;
        for (int c = 0; c < 10; c++) begin
            in_valid = 1'b1; in_id = c + 1; out_ready = (c >= 3); drain = (c >= 3) && (c <= 8);
            if (c == 9) in_valid = 1'b0;
            #1;
            if (c == 3) begin
                checks++; if (occupancy !== 3'd3) begin errors++; $display("[TB] FAIL drain_start_occupancy got=%0d exp=3", occupancy); end
            end
            if ((c >= 3) && (c <= 8)) begin
                checks++; if (in_ready !== 1'b0) begin errors++; $display("[TB] FAIL drain_in_ready cyc=%0d got=%b exp=0", c, in_ready); end
                if (out_valid) begin
                    emits++;
                    checks++; if (data[3] !== emits) begin errors++; $display("[TB] FAIL drain_order cyc=%0d got=%0d exp=%0d", c, data[3], emits); end
                end
                if (drain_done) pulses++;
                checks++; if (drain_done !== (c == 7)) begin errors++; $display("[TB] FAIL drain_done cyc=%0d got=%b exp=%b", c, drain_done, (c == 7)); end
            end
            if (c == 9) begin
                checks++; if ({busy, in_ready} !== 2'b01) begin errors++; $display("[TB] FAIL drain_end_state got=%b exp=01", {busy, in_ready}); end
            end
            tick();
        end
        checks++; if (emits !== 3) begin errors++; $display("[TB] FAIL drain_emits got=%0d exp=3", emits); end
        checks++; if (pulses !== 1) begin errors++; $display("[TB] FAIL drain_pulses got=%0d exp=1", pulses); end
    endtask

    task automatic test_async_reset();
        in_valid = 1'b0; flush = 1'b1;
        #1;
        tick();
        flush = 1'b0;
        #1;
        checks++; if (stage_softReset !== 4'b1111) begin errors++; $display("[TB] FAIL areset_in_flush got=%b exp=1111", stage_softReset); end
        #1;
        reset = 1'b0;
        #1;
        checks++; if ({stage_en, stage_softReset, stage_valid} !== 12'h000) begin errors++; $display("[TB] FAIL areset_vectors got=%h exp=000", {stage_en, stage_softReset, stage_valid}); end
        checks++; if ({in_ready, out_valid, drain_done, busy, occupancy} !== 7'b0) begin errors++; $display("[TB] FAIL areset_flags got=%b exp=0000000", {in_ready, out_valid, drain_done, busy, occupancy}); end
        @(negedge clk);
        reset = 1'b1; in_valid = 1'b1; out_ready = 1'b1; in_id = 9;
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("[TB] FAIL areset_resume_ready got=%b exp=1", in_ready); end
        tick();
        in_valid = 1'b0;
        #1;
        checks++; if ({stage_valid, busy} !== 5'b00011) begin errors++; $display("[TB] FAIL areset_resume_accept got=%b exp=00011", {stage_valid, busy}); end
        for (int c = 0; c < 6; c++) tick();
        #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL areset_end_busy got=%b exp=0", busy); end
    endtask

    initial begin
        test_reset();
        @(negedge clk);
        test_streaming();
        test_backpressure();
        test_bubble_collapse();
        test_flush();
        test_flush_extend();
        test_drain();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
